// File: rtl/tdc_evbuf_pkg.sv
// Shared definitions for the TDC event buffer: CSR register offsets, bit
// positions of the STATUS and CTRL registers, and the STATUS word packer.
package tdc_evbuf_pkg;

    typedef logic [2:0] csr_off_t;

    localparam csr_off_t REG_STATUS  = 3'd0;
    localparam csr_off_t REG_HEAD_TS = 3'd1;
    localparam csr_off_t REG_HEAD_CH = 3'd2;
    localparam csr_off_t REG_POP     = 3'd3;
    localparam csr_off_t REG_CTRL    = 3'd4;
    localparam csr_off_t REG_DROPS   = 3'd5;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_LEVEL_LSB = 8;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam logic [7:0] DROPS_MAX = 8'd255;

    typedef struct packed {
        logic irq_en;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] status_word(input logic       not_empty,
                                                input logic       full,
                                                input logic       overflow,
                                                input logic [7:0] level);
        logic [31:0] w;
        w                          = '0;
        w[ST_NOT_EMPTY]            = not_empty;
        w[ST_FULL]                 = full;
        w[ST_OVERFLOW]             = overflow;
        w[ST_LEVEL_LSB +: 8]       = level;
        return w;
    endfunction

endpackage

// File: rtl/tdc_evbuf_fifo.sv
// Synchronous FIFO with combinational head output; flush clears pointers and
// level and overrides any push/pop in the same cycle.
module tdc_evbuf_fifo #(
    parameter int W  = 35,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem[rd_ptr_q];

    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/tdc_evbuf.sv
// CSR-mapped TDC event buffer: captures {channel, timestamp} into a FIFO,
// exposes head/status over CSR, counts drops, and raises a level IRQ.
module tdc_evbuf
    import tdc_evbuf_pkg::*;
#(
    parameter logic [3:0] csr_addr   = 4'h2,
    parameter int         depth_log2 = 4,
    parameter int         ch_width   = 3
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [13:0]         csr_a,
    input  logic                csr_we,
    input  logic [31:0]         csr_di,
    output logic [31:0]         csr_do,
    input  logic                ev_stb,
    input  logic [31:0]         ev_ts,
    input  logic [ch_width-1:0] ev_ch,
    output logic                irq
);
    localparam int W = 32 + ch_width;

    logic            sel, wr;
    csr_off_t        off;
    logic            pop_req, flush, push_req, pop_ok, push_ok, drop;
    logic [W-1:0]    head;
    logic [depth_log2:0] level;
    logic            full, empty;
    logic [31:0]     level_ext;

    ctrl_t           ctrl_q, ctrl_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drops_q, drops_d;
    logic [31:0]     csr_do_q, csr_do_d;
    logic            unused_bits;

    assign sel      = (csr_a[13:10] == csr_addr);
    assign off      = csr_a[2:0];
    assign wr       = sel & csr_we;
    assign pop_req  = wr & (off == REG_POP);
    assign flush    = wr & (off == REG_CTRL) & csr_di[CTRL_FLUSH];
    assign push_req = ev_stb & ctrl_q.en;
    assign pop_ok   = pop_req & ~empty;
    assign push_ok  = push_req & (~full | pop_ok) & ~flush;
    // A push swallowed by a flush is discarded, not counted as a drop.
    assign drop     = push_req & full & ~pop_ok & ~flush;

    assign unused_bits = ^{csr_a[9:3], csr_di[31:3]};

    tdc_evbuf_fifo #(
        .W  (W),
        .AW (depth_log2)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push_ok),
        .pop   (pop_ok),
        .flush (flush),
        .din   ({ev_ch, ev_ts}),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign level_ext = 32'(level);

    always_comb begin
        ctrl_d  = ctrl_q;
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (wr && off == REG_CTRL) begin
            ctrl_d.en     = csr_di[CTRL_EN];
            ctrl_d.irq_en = csr_di[CTRL_IRQ_EN];
        end
        // A new drop wins over a same-cycle clear of either drop indicator.
        if (drop)
            ovf_d = 1'b1;
        else if (wr && off == REG_STATUS && csr_di[ST_OVERFLOW])
            ovf_d = 1'b0;
        if (wr && off == REG_DROPS)
            drops_d = drop ? 8'd1 : 8'd0;
        else if (drop && drops_q != DROPS_MAX)
            drops_d = drops_q + 8'd1;
    end

    always_comb begin
        csr_do_d = '0;
        if (sel) begin
            case (off)
                REG_STATUS:  csr_do_d = status_word(~empty, full, ovf_q, level_ext[7:0]);
                REG_HEAD_TS: csr_do_d = empty ? 32'd0 : head[31:0];
                REG_HEAD_CH: csr_do_d = empty ? 32'd0 : 32'(head[W-1:32]);
                REG_CTRL:    csr_do_d = {30'd0, ctrl_q.irq_en, ctrl_q.en};
                REG_DROPS:   csr_do_d = {24'd0, drops_q};
                default:     csr_do_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            drops_q  <= '0;
            csr_do_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            drops_q  <= drops_d;
            csr_do_q <= csr_do_d;
        end
    end

    assign csr_do = csr_do_q;
    assign irq    = ctrl_q.irq_en & ~empty;

endmodule

// File: tb/tb_tdc_evbuf.sv
// Directed bench for tdc_evbuf: a vector table for the basic CSR/push/pop
// flow, then hand sequences for full/flush/drop/reset corner cases.
module tb_tdc_evbuf;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [13:0] csr_a = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_di = '0;
    logic [31:0] csr_do;
    logic        ev_stb = 1'b0;
    logic [31:0] ev_ts = '0;
    logic [2:0]  ev_ch = '0;
    logic        irq;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rd_val;
    logic        irq_val;

    localparam logic [3:0] PAGE = 4'h2;
    localparam logic [3:0] BAD_PAGE = 4'h3;

    tdc_evbuf dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .csr_a     (csr_a),
        .csr_we    (csr_we),
        .csr_di    (csr_di),
        .csr_do    (csr_do),
        .ev_stb    (ev_stb),
        .ev_ts     (ev_ts),
        .ev_ch     (ev_ch),
        .irq       (irq)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        we;
        logic [2:0]  off;
        logic [31:0] di;
        logic        stb;
        logic [31:0] ts;
        logic [2:0]  ch;
        logic        chk;
        logic [31:0] exp_do;
        logic        exp_irq;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic we, input logic [2:0] off, input logic [31:0] di,
                                input logic stb, input logic [31:0] ts, input logic [2:0] ch,
                                input logic chk, input logic [31:0] exp_do, input logic exp_irq);
        vec_t v;
        v.we = we; v.off = off; v.di = di; v.stb = stb; v.ts = ts; v.ch = ch;
        v.chk = chk; v.exp_do = exp_do; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit after the posedge.
    task automatic step(input logic we, input logic [2:0] off, input logic [31:0] di,
                        input logic stb, input logic [31:0] ts, input logic [2:0] ch,
                        input logic [3:0] page);
        @(negedge sys_clk);
        csr_a  = {page, 7'd0, off};
        csr_we = we;
        csr_di = di;
        ev_stb = stb;
        ev_ts  = ts;
        ev_ch  = ch;
        @(posedge sys_clk);
        #1;
        rd_val  = csr_do;
        irq_val = irq;
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string name);
        step(1'b0, off, 32'd0, 1'b0, 32'd0, 3'd0, PAGE);
        check(name, rd_val, exp);
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] di);
        step(1'b1, off, di, 1'b0, 32'd0, 3'd0, PAGE);
    endtask

    task automatic push(input logic [31:0] ts);
        step(1'b0, 3'd0, 32'd0, 1'b1, ts, ts[2:0], PAGE);
    endtask

    initial begin
        for (int k = 0; k < 8; k++)
            vecs[k] = mk(1'b0, 3'(k), 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 32'd0, 1'b0);
        vecs[8]  = mk(1'b1, 3'd4, 32'd3, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);
        vecs[9]  = mk(1'b0, 3'd4, 32'd0, 1'b1, 32'h12345678, 3'd5, 1'b1, 32'd3, 1'b1);
        vecs[10] = mk(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 32'h0101, 1'b1);
        vecs[11] = mk(1'b0, 3'd1, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 32'h12345678, 1'b1);
        vecs[12] = mk(1'b0, 3'd2, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 32'd5, 1'b1);
        vecs[13] = mk(1'b1, 3'd3, 32'd1, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);
        vecs[14] = mk(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 32'd0, 1'b0);
        vecs[15] = mk(1'b0, 3'd1, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 32'd0, 1'b0);
        vecs[16] = mk(1'b0, 3'd2, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 32'd0, 1'b0);

        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            step(vecs[k].we, vecs[k].off, vecs[k].di, vecs[k].stb, vecs[k].ts, vecs[k].ch, PAGE);
            if (vecs[k].chk)
                check($sformatf("vec%0d do", k), rd_val, vecs[k].exp_do);
            check($sformatf("vec%0d irq", k), {31'd0, irq_val}, {31'd0, vecs[k].exp_irq});
        end

        // Fill to full, then one dropped push.
        for (int i = 0; i < 16; i++) push(32'(i));
        rd(3'd0, 32'h1003, "full status");
        push(32'd99);
        rd(3'd0, 32'h1007, "overflow status");
        rd(3'd5, 32'd1, "drops after overflow");
        rd(3'd1, 32'd0, "head ts after overflow");
        wr(3'd0, 32'h4);
        rd(3'd0, 32'h1003, "overflow cleared");

        // Push with pop while full: both accepted.
        step(1'b1, 3'd3, 32'd0, 1'b1, 32'hAA, 3'd2, PAGE);
        rd(3'd0, 32'h1003, "full push+pop level");
        rd(3'd5, 32'd1, "full push+pop drops");
        for (int i = 1; i < 16; i++) begin
            rd(3'd1, 32'(i), $sformatf("drain ts%0d", i));
            wr(3'd3, 32'd0);
        end
        rd(3'd1, 32'hAA, "drain last AA");
        wr(3'd3, 32'd0);
        rd(3'd0, 32'd0, "drained status");
        check("drained irq", {31'd0, irq}, 32'd0);

        // Push with pop while empty: pop ignored.
        step(1'b1, 3'd3, 32'd0, 1'b1, 32'h55, 3'd1, PAGE);
        rd(3'd0, 32'h0101, "empty push+pop level");
        rd(3'd1, 32'h55, "empty push+pop head");

        // Flush in the same cycle as a push.
        push(32'h56);
        push(32'h57);
        rd(3'd0, 32'h0301, "three entries");
        step(1'b1, 3'd4, 32'h7, 1'b1, 32'h58, 3'd0, PAGE);
        rd(3'd0, 32'd0, "after flush status");
        rd(3'd5, 32'd1, "after flush drops");
        rd(3'd4, 32'd3, "ctrl flush reads 0");
        check("after flush irq", {31'd0, irq}, 32'd0);

        // Clear races and saturation.
        for (int i = 0; i < 16; i++) push(32'(i));
        step(1'b1, 3'd0, 32'h4, 1'b1, 32'h77, 3'd0, PAGE);
        rd(3'd0, 32'h1007, "ovf set beats clear");
        rd(3'd5, 32'd2, "drops two");
        step(1'b1, 3'd5, 32'd0, 1'b1, 32'h78, 3'd0, PAGE);
        rd(3'd5, 32'd1, "drops clear with drop");
        for (int i = 0; i < 300; i++) push(32'(i));
        rd(3'd5, 32'd255, "drops saturate");

        // Wrong page: reads 0, writes ignored.
        step(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 3'd0, BAD_PAGE);
        check("bad page read", rd_val, 32'd0);
        step(1'b1, 3'd4, 32'd0, 1'b0, 32'd0, 3'd0, BAD_PAGE);
        step(1'b1, 3'd3, 32'd0, 1'b0, 32'd0, 3'd0, BAD_PAGE);
        rd(3'd4, 32'd3, "bad page ctrl kept");
        rd(3'd0, 32'h1007, "bad page level kept");

        // Asynchronous reset in the middle of a read.
        rd(3'd0, 32'h1007, "pre-reset status");
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("reset csr_do", csr_do, 32'd0);
        check("reset irq", {31'd0, irq}, 32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        rd(3'd0, 32'd0, "post-reset status");
        rd(3'd4, 32'd0, "post-reset ctrl");
        rd(3'd5, 32'd0, "post-reset drops");

        // Disabled capture: nothing stored, nothing dropped.
        wr(3'd4, 32'h2);
        for (int i = 0; i < 20; i++) push(32'(i + 100));
        rd(3'd0, 32'd0, "disabled status");
        rd(3'd5, 32'd0, "disabled drops");
        check("disabled irq", {31'd0, irq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
